// File: rtl/rand_pkg.sv
// Shared constants for the multi-channel LFSR random source.
//   DEF_TAPS_32   : default feedback mask, x^32 + x^22 + x^2 + x + 1
//   DEF_SEED      : per-channel default/recovery seeds (distinct, non-zero)
//   MODE_MAP_ZERO : most-negative sample is replaced by 0
//   MODE_REJECT   : most-negative sample is discarded and resampled
package rand_pkg;

    localparam logic [31:0] DEF_TAPS_32 = 32'h8020_0003;

    localparam logic [31:0] DEF_SEED [0:7] = '{
        32'hACE1_2468, 32'h1357_9BDF, 32'hDEAD_BEEF, 32'hC0FF_EE01,
        32'h8BAD_F00D, 32'h0BAD_CAFE, 32'h600D_F00D, 32'hFACE_B00C
    };

    localparam bit MODE_MAP_ZERO = 1'b0;
    localparam bit MODE_REJECT   = 1'b1;

endpackage

// File: rtl/lfsr_rand_ch.sv
// One Fibonacci LFSR channel with seeding and zero-state recovery.
//   clock, reset  : rising-edge clock, async active-high reset
//   step_i        : shift once, feedback enters at bit 0
//   load_i        : load load_data_i (takes priority over step_i)
//   load_data_i   : seed value; zero is replaced by def_seed_i
//   def_seed_i    : reset / recovery seed
//   fb_o          : feedback bit of the current state (the channel's sample bit)
//   lock_o        : 1-cycle pulse after a zero state or zero seed was replaced
module lfsr_rand_ch
    import rand_pkg::*;
#(
    parameter int             W    = 32,
    parameter logic [W-1:0]   TAPS = W'(DEF_TAPS_32)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         step_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic [W-1:0] def_seed_i,
    output logic         fb_o,
    output logic         lock_o
);

    logic [W-1:0] state_q, state_d;
    logic         lock_q, lock_d;

    assign fb_o   = ^(state_q & TAPS);
    assign lock_o = lock_q;

    always_comb begin
        state_d = state_q;
        lock_d  = 1'b0;
        // A zero state would lock the register forever; recover before anything else.
        if (state_q == '0) begin
            state_d = def_seed_i;
            lock_d  = 1'b1;
        end else if (load_i) begin
            if (load_data_i == '0) begin
                state_d = def_seed_i;
                lock_d  = 1'b1;
            end else begin
                state_d = load_data_i;
            end
        end else if (step_i) begin
            state_d = {state_q[W-2:0], fb_o};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= def_seed_i;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: rtl/lfsr_rand_multi.sv
// Multi-channel LFSR random-number source with valid/ready output.
// Each of NUM_CH channels contributes one feedback bit per step; the bits form a
// NUM_CH-bit two's-complement sample, sign-extended to OUT_W.
//   clock, reset : rising-edge clock, async active-high reset
//   en           : allow channels to advance
//   seed_load    : load seed_data into channel seed_ch (stalls stepping this cycle)
//   seed_ch      : target channel for seed_load (out-of-range index is ignored)
//   seed_data    : seed value (zero loads the channel default and pulses lockup)
//   rand_ready   : consumer accepts rand_num
//   rand_valid   : rand_num holds an unconsumed sample
//   rand_num     : sign-extended sample
//   lockup       : 1-cycle pulse when any channel was restored to its default seed
//   sample_cnt   : accepted handshakes, wrapping
//   reject_cnt   : most-negative samples discarded in reject mode, wrapping
module lfsr_rand_multi
    import rand_pkg::*;
#(
    parameter int                NUM_CH = 4,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS_32),
    parameter int                OUT_W  = 32,
    parameter bit                MODE   = MODE_MAP_ZERO,
    parameter int                CNT_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      seed_load,
    input  logic [$clog2(NUM_CH)-1:0] seed_ch,
    input  logic [LFSR_W-1:0]         seed_data,
    input  logic                      rand_ready,
    output logic                      rand_valid,
    output logic [OUT_W-1:0]          rand_num,
    output logic                      lockup,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic [CNT_W-1:0]          reject_cnt
);

    localparam int                SEL_W    = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] MOST_NEG = NUM_CH'(1) << (NUM_CH - 1);

    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  reject_cnt_q, reject_cnt_d;
    logic              advance;
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] lock_vec;

    assign advance = en & ~seed_load & (~valid_q | rand_ready);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Truncation to a narrow LFSR_W could zero a table seed; fall back to 1.
        localparam logic [LFSR_W-1:0] SEED_RAW = LFSR_W'(DEF_SEED[i]);
        localparam logic [LFSR_W-1:0] SEED_I   = (SEED_RAW == '0) ? LFSR_W'(1) : SEED_RAW;

        logic load_ch;
        assign load_ch = seed_load & (seed_ch == SEL_W'(i));

        lfsr_rand_ch #(
            .W    (LFSR_W),
            .TAPS (TAPS)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .step_i      (advance),
            .load_i      (load_ch),
            .load_data_i (seed_data),
            .def_seed_i  (SEED_I),
            .fb_o        (raw[i]),
            .lock_o      (lock_vec[i])
        );
    end

    always_comb begin
        valid_d      = valid_q;
        num_d        = num_q;
        sample_cnt_d = sample_cnt_q;
        reject_cnt_d = reject_cnt_q;
        if (valid_q && rand_ready) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            valid_d      = 1'b0;
        end
        // A fresh sample on the same edge as a handshake overrides the clear above.
        if (advance) begin
            if (raw == MOST_NEG) begin
                if (MODE == MODE_REJECT) begin
                    valid_d      = 1'b0;
                    reject_cnt_d = reject_cnt_q + 1'b1;
                end else begin
                    num_d   = '0;
                    valid_d = 1'b1;
                end
            end else begin
                num_d   = OUT_W'($signed(raw));
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            num_q        <= '0;
            sample_cnt_q <= '0;
            reject_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            num_q        <= num_d;
            sample_cnt_q <= sample_cnt_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign rand_valid = valid_q;
    assign rand_num   = num_q;
    assign lockup     = |lock_vec;
    assign sample_cnt = sample_cnt_q;
    assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_lfsr_rand_multi.sv
module tb_lfsr_rand_multi;

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] SEEDS [0:3] = '{
        32'hACE1_2468, 32'h1357_9BDF, 32'hDEAD_BEEF, 32'hC0FF_EE01
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [1:0]  seed_ch = 2'd0;
    logic [31:0] seed_data = 32'd0;
    logic        rand_ready = 1'b0;

    logic        rand_valid [2];
    logic [31:0] rand_num   [2];
    logic        lockup     [2];
    logic [15:0] sample_cnt [2];
    logic [15:0] reject_cnt [2];

    // reference model, index 0 = map-to-zero instance, 1 = reject instance
    logic [31:0] ms [2][4];
    bit          mv [2];
    logic [31:0] mn [2];
    bit          ml [2];
    int          mcnt [2];
    int          mrej [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lfsr_rand_multi #(.MODE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .en(en), .seed_load(seed_load),
        .seed_ch(seed_ch), .seed_data(seed_data), .rand_ready(rand_ready),
        .rand_valid(rand_valid[0]), .rand_num(rand_num[0]), .lockup(lockup[0]),
        .sample_cnt(sample_cnt[0]), .reject_cnt(reject_cnt[0])
    );

    lfsr_rand_multi #(.MODE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .en(en), .seed_load(seed_load),
        .seed_ch(seed_ch), .seed_data(seed_data), .rand_ready(rand_ready),
        .rand_valid(rand_valid[1]), .rand_num(rand_num[1]), .lockup(lockup[1]),
        .sample_cnt(sample_cnt[1]), .reject_cnt(reject_cnt[1])
    );

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) ms[m][c] = SEEDS[c];
            mv[m] = 0; mn[m] = 32'd0; ml[m] = 0; mcnt[m] = 0; mrej[m] = 0;
        end
    endtask

    // One clock edge of behaviour computed from the current inputs.
    task automatic model_step();
        int  raw, val, fb;
        bit  adv;
        for (int m = 0; m < 2; m++) begin
            raw = 0;
            ml[m] = 0;
            adv = en && !seed_load && (!mv[m] || rand_ready);
            for (int c = 0; c < 4; c++) begin
                if (ms[m][c] == 32'd0) begin
                    ms[m][c] = SEEDS[c];
                    ml[m] = 1;
                end else if (seed_load && int'(seed_ch) == c) begin
                    if (seed_data == 32'd0) begin
                        ms[m][c] = SEEDS[c];
                        ml[m] = 1;
                    end else begin
                        ms[m][c] = seed_data;
                    end
                end else if (adv) begin
                    fb = $countones(ms[m][c] & TAPS) % 2;
                    raw = raw + (fb << c);
                    ms[m][c] = ms[m][c] * 2 + fb;
                end
            end
            if (mv[m] && rand_ready) begin
                mcnt[m]++;
                mv[m] = 0;
            end
            if (adv) begin
                val = (raw >= 8) ? raw - 16 : raw;
                if (val == -8) begin
                    if (m == 0) begin
                        mn[m] = 32'd0; mv[m] = 1;
                    end else begin
                        mrej[m]++; mv[m] = 0;
                    end
                end else begin
                    mn[m] = val; mv[m] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic seed_all(input logic [31:0] d0, d1, d2, d3);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        en = 0;
        seed_load = 1;
        for (int c = 0; c < 4; c++) begin
            seed_ch = 2'(c);
            seed_data = d[c];
            tick();
        end
        seed_load = 0;
    endtask

    task automatic test_reset();
        reset = 1; en = 0; rand_ready = 0; seed_load = 0;
        model_reset();
        #2;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rand_valid[m] !== 1'b0 || rand_num[m] !== 32'd0 || lockup[m] !== 1'b0 ||
                sample_cnt[m] !== 16'd0 || reject_cnt[m] !== 16'd0) begin
                errors++;
                $display("FAIL reset_state m%0d: valid=%b num=%h lock=%b cnt=%0d rej=%0d, required all zero",
                         m, rand_valid[m], rand_num[m], lockup[m], sample_cnt[m], reject_cnt[m]);
            end
        end
        @(negedge clock);
        reset = 0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rand_valid[m] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset m%0d: valid=%b required 0", m, rand_valid[m]);
            end
        end
    endtask

    task automatic test_seeded_samples();
        rand_ready = 1;
        seed_all(32'h8000_0000, 32'h4, 32'h4, 32'h4);
        en = 1;
        tick();
        en = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rand_valid[m] !== 1'b1 || rand_num[m] !== 32'h0000_0001) begin
                errors++;
                $display("FAIL sample_plus1 m%0d: valid=%b num=%h, required 1 00000001",
                         m, rand_valid[m], rand_num[m]);
            end
        end
        seed_all(32'h8000_0000, 32'h4, 32'h4, 32'h8000_0000);
        en = 1;
        tick();
        en = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rand_valid[m] !== 1'b1 || rand_num[m] !== 32'hFFFF_FFF9) begin
                errors++;
                $display("FAIL sample_minus7 m%0d: valid=%b num=%h, required 1 fffffff9",
                         m, rand_valid[m], rand_num[m]);
            end
        end
        seed_all(32'h4, 32'h4, 32'h4, 32'h8000_0000);
        en = 1;
        tick();
        en = 0;
        checks++;
        if (rand_valid[0] !== 1'b1 || rand_num[0] !== 32'd0) begin
            errors++;
            $display("FAIL most_neg_map_zero: valid=%b num=%h, required 1 00000000", rand_valid[0], rand_num[0]);
        end
        checks++;
        if (rand_valid[1] !== 1'b0 || reject_cnt[1] !== 16'd1 || rand_num[1] !== 32'hFFFF_FFF9) begin
            errors++;
            $display("FAIL most_neg_reject: valid=%b rej=%0d num=%h, required 0 1 fffffff9",
                     rand_valid[1], reject_cnt[1], rand_num[1]);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (sample_cnt[m] !== 16'(mcnt[m])) begin
                errors++;
                $display("FAIL sample_cnt_seeded m%0d: got %0d required %0d", m, sample_cnt[m], 16'(mcnt[m]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          c0;
        en = 1; rand_ready = 0;
        tick();
        held = mn[0];
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rand_valid[0] !== 1'b1 || rand_num[0] !== held) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: valid=%b num=%h, required 1 %h", k, rand_valid[0], rand_num[0], held);
            end
            checks++;
            if (rand_valid[1] !== mv[1] || rand_num[1] !== mn[1]) begin
                errors++;
                $display("FAIL stall_reject_inst cyc%0d: valid=%b num=%h, required %b %h",
                         k, rand_valid[1], rand_num[1], mv[1], mn[1]);
            end
        end
        c0 = mcnt[0];
        en = 0; rand_ready = 1;
        tick();
        checks++;
        if (sample_cnt[0] !== 16'(c0 + 1) || rand_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL handshake_count: cnt=%0d valid=%b, required %0d 0", sample_cnt[0], rand_valid[0], 16'(c0 + 1));
        end
        // channels must have been frozen during the stall
        en = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rand_valid[m] !== mv[m] || rand_num[m] !== mn[m]) begin
                    errors++;
                    $display("FAIL post_stall_stream m%0d cyc%0d: valid=%b num=%h, required %b %h",
                             m, k, rand_valid[m], rand_num[m], mv[m], mn[m]);
                end
            end
        end
        en = 0;
    endtask

    task automatic test_zero_seed_lockup();
        rand_ready = 0; en = 0;
        seed_load = 1; seed_ch = 2'd2; seed_data = 32'd0;
        tick();
        seed_load = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (lockup[m] !== 1'b1) begin
                errors++;
                $display("FAIL lockup_pulse m%0d: got %b required 1", m, lockup[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (lockup[m] !== 1'b0) begin
                errors++;
                $display("FAIL lockup_one_cycle m%0d: got %b required 0", m, lockup[m]);
            end
        end
        en = 1; rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rand_valid[m] !== mv[m] || rand_num[m] !== mn[m]) begin
                    errors++;
                    $display("FAIL ch2_default_stream m%0d cyc%0d: valid=%b num=%h, required %b %h",
                             m, k, rand_valid[m], rand_num[m], mv[m], mn[m]);
                end
            end
        end
        en = 0;
    endtask

    task automatic test_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            en         = ($urandom_range(0, 3) != 0);
            rand_ready = ($urandom_range(0, 2) != 0);
            seed_load  = ($urandom_range(0, 9) == 0);
            seed_ch    = 2'($urandom_range(0, 3));
            seed_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rand_valid[m] !== mv[m] || rand_num[m] !== mn[m] || lockup[m] !== ml[m] ||
                    sample_cnt[m] !== 16'(mcnt[m]) || reject_cnt[m] !== 16'(mrej[m])) begin
                    errors++;
                    $display("FAIL random m%0d cyc%0d: v=%b n=%h l=%b c=%0d r=%0d, required v=%b n=%h l=%b c=%0d r=%0d",
                             m, k, rand_valid[m], rand_num[m], lockup[m], sample_cnt[m], reject_cnt[m],
                             mv[m], mn[m], ml[m], 16'(mcnt[m]), 16'(mrej[m]));
                end
            end
        end
        seed_load = 0; en = 0;
    endtask

    task automatic test_reset_mid_transfer();
        en = 1; rand_ready = 0; seed_load = 0;
        tick();
        tick();
        checks++;
        if (rand_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL pending_before_reset: valid=%b required 1", rand_valid[0]);
        end
        #3;
        reset = 1;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rand_valid[m] !== 1'b0 || rand_num[m] !== 32'd0 ||
                sample_cnt[m] !== 16'd0 || reject_cnt[m] !== 16'd0) begin
                errors++;
                $display("FAIL async_reset m%0d: valid=%b num=%h cnt=%0d rej=%0d, required all zero",
                         m, rand_valid[m], rand_num[m], sample_cnt[m], reject_cnt[m]);
            end
        end
        @(negedge clock);
        reset = 0;
        en = 1; rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rand_valid[m] !== mv[m] || rand_num[m] !== mn[m] ||
                    sample_cnt[m] !== 16'(mcnt[m]) || reject_cnt[m] !== 16'(mrej[m])) begin
                    errors++;
                    $display("FAIL post_reset_stream m%0d cyc%0d: v=%b n=%h c=%0d r=%0d, required v=%b n=%h c=%0d r=%0d",
                             m, k, rand_valid[m], rand_num[m], sample_cnt[m], reject_cnt[m],
                             mv[m], mn[m], 16'(mcnt[m]), 16'(mrej[m]));
                end
            end
        end
        en = 0;
    endtask

    initial begin
        test_reset();
        test_seeded_samples();
        test_backpressure();
        test_zero_seed_lockup();
        test_random(400);
        test_reset_mid_transfer();
        test_random(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
